// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM states, default width.
package ex_muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Divide and remainder ops all have funct3[2] set.
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared shift-register datapath: shift-add multiply or restoring divide, one step per step_i.
// After XLEN steps {hi,lo} is the product, or hi = remainder and lo = quotient.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] step_hi_o,
    output logic [XLEN-1:0] step_lo_o
);

    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] m_q, m_d;
    logic            div_mode_q, div_mode_d;

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] mul_hi, mul_lo, div_hi, div_lo;

    // Value of the shift register after one step, exposed so the top can finish on the last step.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        mul_hi  = sum[XLEN:1];
        mul_lo  = {sum[0], lo_q[XLEN-1:1]};
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, m_q};
        if (!diff[XLEN]) begin
            div_hi = diff[XLEN-1:0];
            div_lo = {lo_q[XLEN-2:0], 1'b1};
        end else begin
            div_hi = shifted[XLEN-1:0];
            div_lo = {lo_q[XLEN-2:0], 1'b0};
        end
        step_hi_o = div_mode_q ? div_hi : mul_hi;
        step_lo_o = div_mode_q ? div_lo : mul_lo;
    end

    // Load clears the accumulator and stages operands; each enabled step commits one iteration.
    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        m_d        = m_q;
        div_mode_d = div_mode_q;
        if (load_i) begin
            hi_d       = '0;
            lo_d       = a_i;
            m_d        = b_i;
            div_mode_d = is_div_i;
        end else if (step_i) begin
            hi_d = step_hi_o;
            lo_d = step_lo_o;
        end
    end

    // Datapath registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_q       <= '0;
            lo_q       <= '0;
            m_q        <= '0;
            div_mode_q <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            m_q        <= m_d;
            div_mode_q <= div_mode_d;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, operand sign handling, divide special cases,
// optional single-cycle multiply, and the registered one-cycle result strobe.
module ex_muldiv_unit
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      reg_wr_addr_i,
    input  logic            abort_i,
    output logic            busy_o,
    output logic            hold_flag_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      reg_wr_addr_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;

    logic            a_signed, b_signed, a_neg, b_neg, is_div, is_rem, neg_in;
    logic            div_by_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, special_res, fast_res, calc_res;
    logic [2*XLEN-1:0] prod_fast_mag, prod_fast, prod_calc;
    logic [XLEN-1:0] step_hi, step_lo, quo_fix, rem_fix;
    logic            core_load, core_step;

    // Decode the incoming op: magnitudes, result sign, special divides and the fast product.
    always_comb begin
        a_signed    = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
        b_signed    = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        a_neg       = a_signed & op1_i[XLEN-1];
        b_neg       = b_signed & op2_i[XLEN-1];
        mag_a       = a_neg ? (XLEN'(0) - op1_i) : op1_i;
        mag_b       = b_neg ? (XLEN'(0) - op2_i) : op2_i;
        is_div      = op_is_div(op_i);
        is_rem      = op_i[2] & op_i[1];
        neg_in      = is_rem ? a_neg : (a_neg ^ b_neg);
        div_by_zero = is_div && (op2_i == '0);
        div_ovf     = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                      (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
        if (div_by_zero) begin
            special_res = is_rem ? op1_i : '1;
        end else begin
            special_res = is_rem ? '0 : op1_i;
        end
        prod_fast_mag = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        prod_fast     = neg_in ? ((2*XLEN)'(0) - prod_fast_mag) : prod_fast_mag;
        fast_res      = (op_i == OP_MUL) ? prod_fast[XLEN-1:0] : prod_fast[2*XLEN-1:XLEN];
    end

    // Sign-correct the value the core will hold after its final step.
    always_comb begin
        prod_calc = {step_hi, step_lo};
        if (neg_q) begin
            prod_calc = (2*XLEN)'(0) - prod_calc;
        end
        quo_fix = neg_q ? (XLEN'(0) - step_lo) : step_lo;
        rem_fix = neg_q ? (XLEN'(0) - step_hi) : step_hi;
        if (op_is_div(op_q)) begin
            calc_res = op_q[1] ? rem_fix : quo_fix;
        end else begin
            calc_res = (op_q == OP_MUL) ? prod_calc[XLEN-1:0] : prod_calc[2*XLEN-1:XLEN];
        end
    end

    // FSM next state: capture in IDLE, iterate in CALC, single DONE cycle; abort returns to IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rd_d      = rd_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    op_d  = op_i;
                    neg_d = neg_in;
                    rd_d  = reg_wr_addr_i;
                    cnt_d = '0;
                    if (div_by_zero || div_ovf) begin
                        result_d = special_res;
                        rd_out_d = reg_wr_addr_i;
                        state_d  = ST_DONE;
                    end else if (FAST_MUL && !is_div) begin
                        result_d = fast_res;
                        rd_out_d = reg_wr_addr_i;
                        state_d  = ST_DONE;
                    end else begin
                        core_load = 1'b1;
                        state_d   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    core_step = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        result_d = calc_res;
                        rd_out_d = rd_q;
                        state_d  = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result registers, cleared by synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load_i    (core_load),
        .step_i    (core_step),
        .is_div_i  (is_div),
        .a_i       (mag_a),
        .b_i       (mag_b),
        .step_hi_o (step_hi),
        .step_lo_o (step_lo)
    );

    assign busy_o         = (state_q != ST_IDLE);
    assign hold_flag_o    = start_i | busy_o;
    assign result_valid_o = (state_q == ST_DONE) & ~abort_i;
    assign result_o       = result_q;
    assign reg_wr_addr_o  = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: a shift-add instance and a FAST_MUL instance share inputs.
module tb_ex_muldiv_unit;
    import ex_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [4:0]  rd = '0;
    logic        abort = 1'b0;

    logic        s_busy, s_hold, s_valid;
    logic [31:0] s_result;
    logic [4:0]  s_rd;
    logic        f_busy, f_hold, f_valid;
    logic [31:0] f_result;
    logic [4:0]  f_rd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) dut_slow (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .op1_i(op1), .op2_i(op2),
        .reg_wr_addr_i(rd), .abort_i(abort), .busy_o(s_busy), .hold_flag_o(s_hold),
        .result_valid_o(s_valid), .result_o(s_result), .reg_wr_addr_o(s_rd)
    );

    ex_muldiv_unit #(.XLEN(32), .FAST_MUL(1'b1)) dut_fast (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op), .op1_i(op1), .op2_i(op2),
        .reg_wr_addr_i(rd), .abort_i(abort), .busy_o(f_busy), .hold_flag_o(f_hold),
        .result_valid_o(f_valid), .result_o(f_result), .reg_wr_addr_o(f_rd)
    );

    // One comparison: counts it, and on mismatch counts a failure and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive start for one cycle (cycle N); returns at the falling edge of cycle N+1.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] d);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        op1   = a;
        op2   = b;
        rd    = d;
        #1 checkOutput("hold_at_start", 32'(s_hold), 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for the slow instance's strobe; latency counted in cycles after N.
    task automatic waitStrobe(output int latS, output logic [31:0] resS, output logic [4:0] rdS,
                              output int latF, output logic [31:0] resF);
        latS = -1;
        latF = -1;
        resS = '0;
        rdS  = '0;
        resF = '0;
        for (int k = 1; k <= 40 && latS < 0; k++) begin
            if (k > 1) @(negedge clk);
            if (f_valid && latF < 0) begin
                latF = k;
                resF = f_result;
            end
            if (s_valid) begin
                latS = k;
                resS = s_result;
                rdS  = s_rd;
            end
        end
    endtask

    // Issue one op and compare both instances against the hand-computed result and latencies.
    task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input logic [31:0] expRes,
                         input int expLat, input int expFastLat);
        int latS, latF;
        logic [31:0] resS, resF;
        logic [4:0] rdS;
        applyStimulus(o, a, b, d);
        waitStrobe(latS, resS, rdS, latF, resF);
        checkOutput({tag, "_res"}, resS, expRes);
        checkOutput({tag, "_lat"}, 32'(latS), 32'(expLat));
        checkOutput({tag, "_rd"}, 32'(rdS), 32'(d));
        checkOutput({tag, "_fast_res"}, resF, expRes);
        checkOutput({tag, "_fast_lat"}, 32'(latF), 32'(expFastLat));
    endtask

    initial begin
        int strobes;
        int latS, latF;
        logic [31:0] resS, resF, lastRes;
        logic [4:0] rdS, lastRd;

        $display("[TB] starting");
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(s_busy), 32'd0);
        checkOutput("reset_valid", 32'(s_valid), 32'd0);
        checkOutput("reset_result", s_result, 32'd0);
        checkOutput("reset_rd", 32'(s_rd), 32'd0);
        checkOutput("reset_hold", 32'(s_hold), 32'd0);
        rst = 1'b1;

        runOp("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33, 33);
        @(negedge clk);
        checkOutput("result_held", s_result, 32'd14);
        checkOutput("rd_held", 32'(s_rd), 32'd5);
        checkOutput("valid_dropped", 32'(s_valid), 32'd0);

        runOp("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 33, 33);
        runOp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33, 33);
        runOp("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33, 33);
        runOp("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd12, 32'hFFFF_FFF2, 33, 33);
        runOp("rem_100_m7", OP_REM, 32'd100, 32'hFFFF_FFF9, 5'd13, 32'd2, 33, 33);
        runOp("divu_by0", OP_DIVU, 32'h0000_1234, 32'd0, 5'd14, 32'hFFFF_FFFF, 1, 1);
        runOp("remu_by0", OP_REMU, 32'd5, 32'd0, 5'd15, 32'd5, 1, 1);
        runOp("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1, 1);
        runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1, 1);
        runOp("divu_big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, 33, 33);

        runOp("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd19, 32'h4000_0000, 33, 1);
        runOp("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'hFFFF_FFFE, 33, 1);
        runOp("mul_min", OP_MUL, 32'h8000_0000, 32'h8000_0000, 5'd21, 32'd0, 33, 1);
        runOp("mulhsu_m1_2", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd22, 32'hFFFF_FFFF, 33, 1);
        runOp("mul_7_m6", OP_MUL, 32'd7, 32'hFFFF_FFFA, 5'd23, 32'hFFFF_FFD6, 33, 1);

        // Abort in cycle N+10 of a DIV, restart in N+11.
        strobes = 0;
        applyStimulus(OP_DIV, 32'd1000, 32'd3, 5'd7);
        checkOutput("busy_in_calc", 32'(s_busy), 32'd1);
        checkOutput("hold_in_calc", 32'(s_hold), 32'd1);
        repeat (9) begin
            @(negedge clk);
            if (s_valid) strobes++;
        end
        abort = 1'b1;
        #1 if (s_valid) strobes++;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy_clear", 32'(s_busy), 32'd0);
        checkOutput("abort_no_strobe", 32'(strobes), 32'd0);
        start = 1'b1;
        op    = OP_DIVU;
        op1   = 32'd100;
        op2   = 32'd7;
        rd    = 5'd8;
        @(negedge clk);
        start = 1'b0;
        waitStrobe(latS, resS, rdS, latF, resF);
        checkOutput("after_abort_res", resS, 32'd14);
        checkOutput("after_abort_lat", 32'(latS), 32'd33);
        checkOutput("after_abort_rd", 32'(rdS), 32'd8);

        // Start together with abort in IDLE must not be captured.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_start_ignored", 32'(s_busy), 32'd0);

        // Reset in the middle of CALC clears everything at the next edge.
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd9);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_busy", 32'(s_busy), 32'd0);
        checkOutput("midreset_valid", 32'(s_valid), 32'd0);
        checkOutput("midreset_result", s_result, 32'd0);
        checkOutput("midreset_rd", 32'(s_rd), 32'd0);
        checkOutput("midreset_fast_result", f_result, 32'd0);
        rst = 1'b1;

        // A start pulse while busy must be ignored: exactly one strobe for the first op.
        strobes = 0;
        lastRes = '0;
        lastRd  = '0;
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd3);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = OP_DIVU;
        op1   = 32'd100;
        op2   = 32'd10;
        rd    = 5'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (45) begin
            if (s_valid) begin
                strobes++;
                lastRes = s_result;
                lastRd  = s_rd;
            end
            @(negedge clk);
        end
        checkOutput("busy_start_strobes", 32'(strobes), 32'd1);
        checkOutput("busy_start_res", lastRes, 32'd14);
        checkOutput("busy_start_rd", 32'(lastRd), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
